// File: rtl/baseball_pkg.sv
// Shared definitions for the baseball game controller.
//   - play event codes carried on ev_code
//   - controller FSM state encoding
//   - runs_to_onehot: run count (0..4) to the scoreboard's one-hot increment
package baseball_pkg;

    localparam logic [2:0] EV_SINGLE  = 3'd0;
    localparam logic [2:0] EV_DOUBLE  = 3'd1;
    localparam logic [2:0] EV_TRIPLE  = 3'd2;
    localparam logic [2:0] EV_HOMERUN = 3'd3;
    localparam logic [2:0] EV_WALK    = 3'd4;
    localparam logic [2:0] EV_OUT     = 3'd5;

    typedef enum logic [1:0] {
        StIdle       = 2'd0,
        StApply      = 2'd1,
        StSideChange = 2'd2,
        StGameOver   = 2'd3
    } state_t;

    // 0 runs -> 0000, n runs -> bit n-1 set
    function automatic logic [3:0] runs_to_onehot(input logic [2:0] runs);
        logic [3:0] onehot;
        case (runs)
            3'd1:    onehot = 4'b0001;
            3'd2:    onehot = 4'b0010;
            3'd3:    onehot = 4'b0100;
            3'd4:    onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/baseball_advance.sv
// Combinational runner-advancement for one play.
//   base     in  3  current occupancy: [2] = 1st, [1] = 2nd, [0] = 3rd
//   ev_code  in  3  play event code
//   nxt_base out 3  occupancy after the play (unchanged for OUT and reserved codes)
//   runs     out 3  runs scored by the play (0..4)
//   is_out   out 1  play is an out
module baseball_advance
    import baseball_pkg::*;
(
    input  logic [2:0] base,
    input  logic [2:0] ev_code,
    output logic [2:0] nxt_base,
    output logic [2:0] runs,
    output logic       is_out
);

    // path[k] = runner standing on base k; the batter sits at home (k = 0).
    // A hit of n bases is a left shift by n; anything at k >= 4 has crossed the plate.
    logic [7:0] path;
    logic [7:0] moved;

    always_comb begin
        path     = {4'b0000, base[0], base[1], base[2], 1'b1};
        moved    = '0;
        nxt_base = base;
        runs     = '0;
        is_out   = 1'b0;
        case (ev_code)
            EV_SINGLE, EV_DOUBLE, EV_TRIPLE, EV_HOMERUN: begin
                moved    = path << ({1'b0, ev_code[1:0]} + 3'd1);
                nxt_base = {moved[1], moved[2], moved[3]};
                runs     = 3'(moved[4]) + 3'(moved[5]) + 3'(moved[6]) + 3'(moved[7]);
            end
            EV_WALK: begin
                // only forced runners move: each base fills if everything behind it is full
                nxt_base[2] = 1'b1;
                nxt_base[1] = base[1] | base[2];
                nxt_base[0] = base[0] | (base[2] & base[1]);
                runs        = {2'b00, &base};
            end
            EV_OUT: begin
                is_out = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/baseball_game_ctrl.sv
// Game-state sequencer feeding the scoreboard LED block.
//   clk          in   1      clock
//   reset_n      in   1      asynchronous, active-low reset
//   ev_valid     in   1      play event present
//   ev_code      in   3      play event code (see baseball_pkg)
//   ev_ready     out  1      controller can accept an event
//   new_game     in   1      synchronous restart pulse, overrides everything
//   team         out  1      batting team: 0 = visitors, 1 = home
//   base         out  3      occupancy: [2] = 1st, [1] = 2nd, [0] = 3rd
//   add_to_score out  4      one-hot runs for this play, high for one cycle
//   outs         out  2      outs in the current half-inning
//   inning       out  INN_W  current inning, starts at 1
//   game_over    out  1      sticky until new_game or reset
module baseball_game_ctrl
    import baseball_pkg::*;
#(
    parameter int unsigned NUM_INNINGS = 9,
    parameter int unsigned INN_W       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ev_valid,
    input  logic [2:0]       ev_code,
    output logic             ev_ready,
    input  logic             new_game,
    output logic             team,
    output logic [2:0]       base,
    output logic [3:0]       add_to_score,
    output logic [1:0]       outs,
    output logic [INN_W-1:0] inning,
    output logic             game_over
);

    state_t             state_q, state_d;
    logic               team_q, team_d;
    logic [2:0]         base_q, base_d;
    logic [3:0]         add_q, add_d;
    logic [1:0]         outs_q, outs_d;
    logic [INN_W-1:0]   inning_q, inning_d;
    logic               over_q, over_d;
    // set when the accepted play was the third out, consumed in APPLY
    logic               side_q, side_d;

    logic [2:0]         adv_base;
    logic [2:0]         adv_runs;
    logic               adv_is_out;

    baseball_advance u_advance (
        .base     (base_q),
        .ev_code  (ev_code),
        .nxt_base (adv_base),
        .runs     (adv_runs),
        .is_out   (adv_is_out)
    );

    assign ev_ready = (state_q == StIdle) && !new_game;

    always_comb begin
        state_d  = state_q;
        team_d   = team_q;
        base_d   = base_q;
        add_d    = 4'b0000;
        outs_d   = outs_q;
        inning_d = inning_q;
        over_d   = over_q;
        side_d   = side_q;
        if (new_game) begin
            state_d  = StIdle;
            team_d   = 1'b0;
            base_d   = 3'b000;
            outs_d   = 2'd0;
            inning_d = INN_W'(1);
            over_d   = 1'b0;
            side_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ev_valid) begin
                        state_d = StApply;
                        // an out leaves bases alone and scores nothing, so the
                        // advance results are safe to take unconditionally
                        base_d  = adv_base;
                        add_d   = runs_to_onehot(adv_runs);
                        if (adv_is_out) begin
                            if (outs_q == 2'd2) begin
                                side_d = 1'b1;
                            end else begin
                                outs_d = outs_q + 2'd1;
                            end
                        end
                    end
                end
                StApply: begin
                    state_d = side_q ? StSideChange : StIdle;
                    side_d  = 1'b0;
                end
                StSideChange: begin
                    if (team_q && (inning_q == INN_W'(NUM_INNINGS))) begin
                        // end of the last bottom half: freeze the display as it stands
                        state_d = StGameOver;
                        over_d  = 1'b1;
                    end else begin
                        state_d = StIdle;
                        base_d  = 3'b000;
                        outs_d  = 2'd0;
                        team_d  = !team_q;
                        if (team_q) begin
                            inning_d = inning_q + INN_W'(1);
                        end
                    end
                end
                StGameOver: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            team_q   <= 1'b0;
            base_q   <= 3'b000;
            add_q    <= 4'b0000;
            outs_q   <= 2'd0;
            inning_q <= INN_W'(1);
            over_q   <= 1'b0;
            side_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            team_q   <= team_d;
            base_q   <= base_d;
            add_q    <= add_d;
            outs_q   <= outs_d;
            inning_q <= inning_d;
            over_q   <= over_d;
            side_q   <= side_d;
        end
    end

    assign team         = team_q;
    assign base         = base_q;
    assign add_to_score = add_q;
    assign outs         = outs_q;
    assign inning       = inning_q;
    assign game_over    = over_q;

endmodule
